// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: FSM states, op encoding, offset width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        WB      = 2'd3
    } mau_state_t;

    typedef enum logic {
        OP_STORE = 1'b0,
        OP_LOAD  = 1'b1
    } mau_op_t;

    // Width of the signed immediate offset used when MAU_OFFSET_EN is defined.
    localparam int OFFSET_W = 3;

endpackage

// File: rtl/mau_addr_gen.sv
// Effective-address generator: BaseAddr resized to DA bits, plus signed Offset under MAU_OFFSET_EN.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the inputs every cycle.
module mau_addr_gen
    import mau_pkg::*;
#(
    parameter int W  = 8,
    parameter int DA = 8
) (
    input  logic [W-1:0]        base,
`ifdef MAU_OFFSET_EN
    input  logic [OFFSET_W-1:0] offset,
`endif
    output logic [DA-1:0]       addr
);

    logic [DA-1:0] base_ext;

    // Fit the register-file value onto the memory address bus.
    generate
        if (W >= DA) begin : g_trunc
            assign base_ext = base[DA-1:0];
        end else begin : g_zext
            assign base_ext = {{(DA-W){1'b0}}, base};
        end
    endgenerate

`ifdef MAU_OFFSET_EN
    logic [DA-1:0] offset_ext;

    // Sign-extend the immediate; the DA-bit add wraps modulo 2**DA by construction.
    assign offset_ext = DA'($signed(offset));
    assign addr       = base_ext + offset_ext;
`else
    assign addr       = base_ext;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage between RegFile read ports and its write port (option: MAU_OFFSET_EN).
// Latency: store writes memory 1 cycle after accept; load writes RegFile 3 cycles after accept.
// Backpressure: Busy is high outside IDLE; Start while busy (incl. the Done cycle) is dropped, not queued.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int W  = 8,
    parameter int A  = 3,
    parameter int DA = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                IsLoad,
    input  logic [W-1:0]        BaseAddr,
    input  logic [W-1:0]        StoreData,
    input  logic [A-1:0]        DestReg,
`ifdef MAU_OFFSET_EN
    input  logic [OFFSET_W-1:0] Offset,
`endif
    output logic [DA-1:0]       MemAddr,
    output logic                MemWrEn,
    output logic [W-1:0]        MemWrData,
    input  logic [W-1:0]        MemRdData,
    output logic                RfWriteEn,
    output logic [A-1:0]        RfWaddr,
    output logic [W-1:0]        RfDataIn,
    output logic                Busy,
    output logic                Done
);

    mau_state_t    state;
    mau_state_t    state_next;
    mau_op_t       op_q;
    logic [DA-1:0] addr_q;
    logic [W-1:0]  data_q;
    logic [A-1:0]  dest_q;
    logic [W-1:0]  load_q;
    logic [DA-1:0] eff_addr;
    logic          accept;

    mau_addr_gen #(
        .W  (W),
        .DA (DA)
    ) u_addr_gen (
        .base   (BaseAddr),
`ifdef MAU_OFFSET_EN
        .offset (Offset),
`endif
        .addr   (eff_addr)
    );

    // A request is taken only from IDLE; the Done cycle is never IDLE so it drops Start too.
    assign accept = (state == IDLE) && Start;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latches: loaded on accept, then frozen until the op completes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q   <= OP_STORE;
            addr_q <= '0;
            data_q <= '0;
            dest_q <= '0;
        end else if (accept) begin
            op_q   <= IsLoad ? OP_LOAD : OP_STORE;
            addr_q <= eff_addr;
            data_q <= StoreData;
            dest_q <= DestReg;
        end
    end

    // Load result register: memory data is valid during RD_WAIT, one cycle after ISSUE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            load_q <= '0;
        end else if (state == RD_WAIT) begin
            load_q <= MemRdData;
        end
    end

    // Next-state and outputs; every idle output reads 0 rather than a stale latch.
    always_comb begin
        state_next = state;
        MemAddr    = '0;
        MemWrEn    = 1'b0;
        MemWrData  = '0;
        RfWriteEn  = 1'b0;
        RfWaddr    = '0;
        RfDataIn   = '0;
        Done       = 1'b0;
        Busy       = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                MemAddr = addr_q;
                if (op_q == OP_STORE) begin
                    // Reset in the same cycle must not corrupt memory.
                    MemWrEn    = !Reset;
                    MemWrData  = data_q;
                    Done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                MemAddr    = addr_q;
                state_next = WB;
            end
            WB: begin
                RfWriteEn  = !Reset;
                RfWaddr    = dest_q;
                RfDataIn   = load_q;
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small synchronous data memory (1-cycle read).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises Start while busy and in the Done cycle.
module tb_mem_access_unit;

    localparam int W  = 8;
    localparam int A  = 3;
    localparam int DA = 8;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          IsLoad;
    logic [W-1:0]  BaseAddr;
    logic [W-1:0]  StoreData;
    logic [A-1:0]  DestReg;
`ifdef MAU_OFFSET_EN
    logic [2:0]    Offset;
`endif
    logic [DA-1:0] MemAddr;
    logic          MemWrEn;
    logic [W-1:0]  MemWrData;
    logic [W-1:0]  MemRdData;
    logic          RfWriteEn;
    logic [A-1:0]  RfWaddr;
    logic [W-1:0]  RfDataIn;
    logic          Busy;
    logic          Done;

    int vectors;
    int miscompares;

    // Bench-side memory with a preload port so the design never sees the setup writes.
    logic [W-1:0]  mem [0:(1<<DA)-1];
    logic          pre_we;
    logic [DA-1:0] pre_addr;
    logic [W-1:0]  pre_dat;

    mem_access_unit #(.W(W), .A(A), .DA(DA)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .IsLoad    (IsLoad),
        .BaseAddr  (BaseAddr),
        .StoreData (StoreData),
        .DestReg   (DestReg),
`ifdef MAU_OFFSET_EN
        .Offset    (Offset),
`endif
        .MemAddr   (MemAddr),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData),
        .RfWriteEn (RfWriteEn),
        .RfWaddr   (RfWaddr),
        .RfDataIn  (RfDataIn),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous memory: write-then-read ordering is irrelevant here (no same-address RAW in the bench).
    always @(posedge Clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_dat;
        end else if (MemWrEn) begin
            mem[MemAddr] <= MemWrData;
        end
        MemRdData <= mem[MemAddr];
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [DA-1:0] a, input logic [W-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_dat  = d;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        Start       = 1'b0;
        IsLoad      = 1'b0;
        BaseAddr    = '0;
        StoreData   = '0;
        DestReg     = '0;
`ifdef MAU_OFFSET_EN
        Offset      = '0;
`endif
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_dat     = '0;

        // Reset with memory preloads.
        preload(8'h00, 8'h00);
        preload(8'h10, 8'h77);
        preload(8'h40, 8'h5A);
        Reset = 1'b0;
        tick(); tick(); tick();
        check("rst_busy",   {7'd0, Busy},      8'h00);
        check("rst_done",   {7'd0, Done},      8'h00);
        check("rst_memwe",  {7'd0, MemWrEn},   8'h00);
        check("rst_rfwe",   {7'd0, RfWriteEn}, 8'h00);
        check("rst_maddr",  MemAddr,           8'h00);

        // Store 0xA5 to 0x20.
        Start = 1'b1; IsLoad = 1'b0; BaseAddr = 8'h20; StoreData = 8'hA5;
        tick();
        Start = 1'b0;
        check("st_maddr",   MemAddr,           8'h20);
        check("st_we",      {7'd0, MemWrEn},   8'h01);
        check("st_wdata",   MemWrData,         8'hA5);
        check("st_done",    {7'd0, Done},      8'h01);
        check("st_busy",    {7'd0, Busy},      8'h01);
        tick();
        check("st_idle",    {7'd0, Busy},      8'h00);
        check("st_done0",   {7'd0, Done},      8'h00);
        check("st_we0",     {7'd0, MemWrEn},   8'h00);
        check("st_maddr0",  MemAddr,           8'h00);
        check("st_mem",     mem[8'h20],        8'hA5);

        // Load from 0x20 into r5, with a stray Start during RD_WAIT and WB.
        Start = 1'b1; IsLoad = 1'b1; BaseAddr = 8'h20; DestReg = 3'd5;
        tick();
        Start = 1'b0;
        check("ld_issue_we",   {7'd0, MemWrEn},   8'h00);
        check("ld_issue_addr", MemAddr,           8'h20);
        check("ld_issue_done", {7'd0, Done},      8'h00);
        tick();
        check("ld_wait_addr",  MemAddr,           8'h20);
        check("ld_wait_rfwe",  {7'd0, RfWriteEn}, 8'h00);
        Start = 1'b1; IsLoad = 1'b0; BaseAddr = 8'h40; StoreData = 8'h3C; DestReg = 3'd2;
        tick();
        check("ld_wb_rfwe",    {7'd0, RfWriteEn}, 8'h01);
        check("ld_wb_waddr",   {5'd0, RfWaddr},   8'h05);
        check("ld_wb_data",    RfDataIn,          8'hA5);
        check("ld_wb_done",    {7'd0, Done},      8'h01);
        check("ld_wb_maddr",   MemAddr,           8'h00);
        tick();
        Start = 1'b0;
        check("ld_end_busy",   {7'd0, Busy},      8'h00);
        check("ld_end_rfwe",   {7'd0, RfWriteEn}, 8'h00);
        check("ld_end_waddr",  {5'd0, RfWaddr},   8'h00);
        check("ld_end_data",   RfDataIn,          8'h00);
        tick();
        check("ign_busy",      {7'd0, Busy},      8'h00);
        check("ign_memwe",     {7'd0, MemWrEn},   8'h00);
        check("ign_mem40",     mem[8'h40],        8'h5A);

        // Back-to-back stores: Start held through the Done cycle is dropped, next accept one cycle later.
        Start = 1'b1; IsLoad = 1'b0; BaseAddr = 8'h30; StoreData = 8'h11;
        tick();
        check("b2b_a_addr",    MemAddr,           8'h30);
        BaseAddr = 8'h31; StoreData = 8'h22;
        tick();
        check("b2b_gap_busy",  {7'd0, Busy},      8'h00);
        tick();
        Start = 1'b0;
        check("b2b_b_addr",    MemAddr,           8'h31);
        check("b2b_b_wdata",   MemWrData,         8'h22);
        tick();
        check("b2b_mem30",     mem[8'h30],        8'h11);
        check("b2b_mem31",     mem[8'h31],        8'h22);

        // Reset landing on the ISSUE cycle of a store to 0x10.
        Start = 1'b1; IsLoad = 1'b0; BaseAddr = 8'h10; StoreData = 8'hEE;
        tick();
        Start = 1'b0;
        Reset = 1'b1;
        #1;
        check("rsti_we",       {7'd0, MemWrEn},   8'h00);
        tick();
        check("rsti_busy",     {7'd0, Busy},      8'h00);
        check("rsti_mem10",    mem[8'h10],        8'h77);
        Reset = 1'b0;
        tick();
        check("rsti_done",     {7'd0, Done},      8'h00);
        check("rsti_maddr",    MemAddr,           8'h00);

`ifdef MAU_OFFSET_EN
        // Offset wrap in both directions.
        Start = 1'b1; IsLoad = 1'b0; BaseAddr = 8'hFF; Offset = 3'b010; StoreData = 8'h01;
        tick();
        Start = 1'b0;
        check("off_pos",       MemAddr,           8'h01);
        tick();
        Start = 1'b1; BaseAddr = 8'h00; Offset = 3'b111;
        tick();
        Start = 1'b0;
        check("off_neg",       MemAddr,           8'hFF);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
